// File: rtl/cas_player.sv
// cas_player: cassette tape playback source.
// Stores a .cas image received over the ioctl download channel and, while the
// motor is on, emits it LSB-first as FSK: one HALF0_CYC-high/HALF0_CYC-low
// cycle per 0 bit, one HALF1_CYC-high/HALF1_CYC-low cycle per 1 bit.
// Ports:
//   clk, reset                     clock, async active-high reset
//   sel, ioctl_download            download qualifier (both high = loading)
//   ioctl_wr/addr/data             byte write into tape RAM
//   motor                          1 = play, 0 = pause
//   rewind                         synchronous return to byte 0
//   cas_out                        FSK waveform (registered)
//   playing                        motor on and a bit in progress
//   done                           last byte fully emitted
//   byte_pos                       index of the byte being emitted
module cas_player #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned HALF0_CYC = 20833,
    parameter int unsigned HALF1_CYC = 10417
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              motor,
    input  logic              rewind,
    output logic              cas_out,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W-1:0] byte_pos
);
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] LAST0 = CNT_W'(HALF0_CYC - 1);
    localparam logic [CNT_W-1:0] LAST1 = CNT_W'(HALF1_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HI, S_LO, S_DONE} state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_data;
    logic [7:0]        shift;
    logic [7:0]        next_byte;
    logic [ADDR_W-1:0] bp;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  tape_len;
    logic [LEN_W-1:0]  wr_end;
    logic [LEN_W-1:0]  len_base;
    logic [LEN_W-1:0]  bp_plus1;
    logic [CNT_W-1:0]  half_cnt;
    logic [CNT_W-1:0]  half_last;
    logic [2:0]        bit_idx;
    logic              dl;
    logic              dl_q;
    logic              dl_rise;
    logic              half_end;
    logic              more_bytes;

    assign dl       = sel & ioctl_download;
    assign dl_rise  = dl & ~dl_q;
    // One bit wider than the address so a write to the top address saturates at 2^ADDR_W.
    assign wr_end   = LEN_W'(ioctl_addr) + LEN_W'(1);
    assign len_base = dl_rise ? '0 : tape_len;

    // IDLE reads the byte about to start; otherwise the read port prefetches the following byte.
    assign rd_addr    = (state == S_IDLE) ? bp : bp + ADDR_W'(1);
    assign half_last  = shift[0] ? LAST1 : LAST0;
    assign half_end   = (half_cnt == half_last);
    assign bp_plus1   = LEN_W'(bp) + LEN_W'(1);
    assign more_bytes = (bp_plus1 < tape_len);

    assign playing = motor & ((state == S_HI) | (state == S_LO));

    // Tape RAM: single write port from the download, one synchronous read port.
    always_ff @(posedge clk) begin
        if (dl && ioctl_wr) begin
            mem[ioctl_addr] <= ioctl_data;
        end
        rd_data <= mem[rd_addr];
    end

    // Playback FSM. cas_out, done and byte_pos are a registered view of the state
    // one clock behind, so every half-cycle keeps its exact width at the pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            dl_q      <= 1'b0;
            tape_len  <= '0;
            bp        <= '0;
            byte_pos  <= '0;
            shift     <= '0;
            next_byte <= '0;
            bit_idx   <= '0;
            half_cnt  <= '0;
            cas_out   <= 1'b0;
            done      <= 1'b0;
        end else begin
            dl_q     <= dl;
            cas_out  <= (state == S_HI);
            done     <= (state == S_DONE);
            byte_pos <= bp;

            if (dl) begin
                // Loading: playback parked in IDLE, motor ignored.
                state    <= S_IDLE;
                half_cnt <= '0;
                tape_len <= (ioctl_wr && (wr_end > len_base)) ? wr_end : len_base;
                if (dl_rise) begin
                    bp       <= '0;
                    byte_pos <= '0;
                    cas_out  <= 1'b0;
                    done     <= 1'b0;
                end
            end else if (rewind) begin
                state    <= S_IDLE;
                half_cnt <= '0;
                bp       <= '0;
                byte_pos <= '0;
                cas_out  <= 1'b0;
                done     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        half_cnt <= '0;
                        if (motor) begin
                            state <= (tape_len == '0) ? S_DONE : S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        shift    <= rd_data;
                        bit_idx  <= '0;
                        half_cnt <= '0;
                        state    <= S_HI;
                    end
                    S_HI: begin
                        if (motor) begin
                            if (half_end) begin
                                half_cnt <= '0;
                                state    <= S_LO;
                                // Read port has held RAM[bp+1] for at least one clock by now.
                                if (bit_idx == 3'd0) begin
                                    next_byte <= rd_data;
                                end
                            end else begin
                                half_cnt <= half_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_LO: begin
                        if (motor) begin
                            if (half_end) begin
                                half_cnt <= '0;
                                if (bit_idx != 3'd7) begin
                                    shift   <= {1'b0, shift[7:1]};
                                    bit_idx <= bit_idx + 3'd1;
                                    state   <= S_HI;
                                end else if (more_bytes) begin
                                    bp      <= bp + ADDR_W'(1);
                                    shift   <= next_byte;
                                    bit_idx <= '0;
                                    state   <= S_HI;
                                end else begin
                                    state <= S_DONE;
                                end
                            end else begin
                                half_cnt <= half_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        half_cnt <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
